// File: rtl/rv_alu_pkg.sv
// Shared rv32i datapath constants and types used by the adder and its consumers.
package rv_alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

endpackage

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead slice; emits group generate/propagate alongside the ripple carry-out.
module cla4_group (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       g,
  output logic       p,
  output logic       cout
);

  logic [3:0] gi;
  logic [3:0] pi;
  logic [3:0] c;

  always_comb begin
    gi = a & b;
    pi = a ^ b;

    c[0] = cin;
    c[1] = gi[0] | (pi[0] & cin);
    c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
    c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & cin);

    g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
    p = &pi;
    cout = g | (p & cin);

    sum = pi ^ c;
  end

endmodule

// File: rtl/rv_adder.sv
// Registered two's-complement adder/subtractor built from a ripple of 4-bit lookahead groups.
module rv_adder
  import rv_alu_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned NGroups = WIDTH / 4;

  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   res_d;
  logic [NGroups:0]   c;
  logic [NGroups-1:0] gg;
  logic [NGroups-1:0] pg;
  flags_t             flags_d;

  logic               out_valid_q;
  logic [WIDTH-1:0]   res_q;
  flags_t             flags_q;

  // Subtraction as op1 + ~op2 + 1: the +1 enters as the chain carry-in.
  assign b_eff = sub ? ~op2 : op2;
  assign c[0]  = sub;

  for (genvar i = 0; i < NGroups; i++) begin : g_cla
    cla4_group u_cla4_group (
      .a    (op1[4*i +: 4]),
      .b    (b_eff[4*i +: 4]),
      .cin  (c[i]),
      .sum  (res_d[4*i +: 4]),
      .g    (gg[i]),
      .p    (pg[i]),
      .cout (c[i+1])
    );

    // Group generate/propagate must reproduce the rippled carry.
    always_comb begin
      assert (c[i+1] == (gg[i] | (pg[i] & c[i])));
    end
  end

  always_comb begin
    flags_d          = '0;
    flags_d.carry    = c[NGroups];
    flags_d.overflow = (op1[WIDTH-1] == b_eff[WIDTH-1]) && (res_d[WIDTH-1] != op1[WIDTH-1]);
    flags_d.zero     = (res_d == '0);
    flags_d.negative = res_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;

endmodule

// File: tb/tb_rv_adder.sv
// Scoreboard bench for rv_adder: directed vectors queue expected results, a monitor checks outputs.
module tb_rv_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        sub;
  logic        out_valid;
  logic [31:0] res;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        negative;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  rv_adder #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .op1       (op1),
    .op2       (op2),
    .sub       (sub),
    .out_valid (out_valid),
    .res       (res),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (out_valid) begin
      got = '{res: res, c: carry, v: overflow, z: zero, n: negative};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid got res=%h c=%b v=%b z=%b n=%b required none",
                 got.res, got.c, got.v, got.z, got.n);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL result got res=%h c=%b v=%b z=%b n=%b required res=%h c=%b v=%b z=%b n=%b",
                   got.res, got.c, got.v, got.z, got.n,
                   want.res, want.c, want.v, want.z, want.n);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic s);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    op1      = a;
    op2      = b;
    sub      = s;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] r, input logic c, input logic v,
                       input logic z, input logic n);
    drive(1'b0, 1'b1, a, b, s);
    exp_q.push_back('{res: r, c: c, v: v, z: z, n: n});
  endtask

  task automatic check_regs(input string name, input logic ov, input logic [31:0] r,
                            input logic [3:0] f);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== ov || res !== r || {carry, overflow, zero, negative} !== f) begin
      errors++;
      $display("FAIL %s got out_valid=%b res=%h flags=%b required out_valid=%b res=%h flags=%b",
               name, out_valid, res, {carry, overflow, zero, negative}, ov, r, f);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    op1      = 32'd5;
    op2      = 32'd7;
    sub      = 1'b0;

    // Reset held two cycles with a live operation on the inputs.
    check_regs("reset_cycle1", 1'b0, 32'h0, 4'b0000);
    check_regs("reset_cycle2", 1'b0, 32'h0, 4'b0000);

    issue(32'd5,        32'd7,        1'b0, 32'd12,       1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h00000002, 32'h00000001, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h00000002, 32'hFFFFFFFF, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(32'h00000002, 32'h00000001, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_regs("idle_after_burst", 1'b0, 32'h00000000, 4'b1010);

    // Back-to-back stream then idle: last result must hold.
    issue(32'd10,       32'd20,       1'b0, 32'd30,       1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'd100,      32'd1,        1'b1, 32'd99,       1'b1, 1'b0, 1'b0, 1'b0);
    issue(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'hA0000000, 32'hA0000000, 1'b0, 32'h40000000, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'hDEADBEEF, 32'h1, 1'b1);
    check_regs("hold_1", 1'b0, 32'h40000000, 4'b1100);
    check_regs("hold_2", 1'b0, 32'h40000000, 4'b1100);

    // Operation sampled together with reset is discarded.
    drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check_regs("reset_mid_op", 1'b0, 32'h0, 4'b0000);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d required pending=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
